// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer
// Accepts one vector load/store, issues one single-element data cache access
// per active element (unit-stride or strided), and returns the packed load
// result together with a one-cycle completion pulse.
// Optional feature macro: VECTOR_MASK_EN (adds req_mask; masked-off elements
// are skipped and their result slots stay zero).

`ifndef ONE_BYTE
`define ONE_BYTE 3'd0
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'd1
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'd2
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'd3
`endif
`ifndef D_CACHE_NOP
`define D_CACHE_NOP 2'd0
`endif
`ifndef D_CACHE_LOAD
`define D_CACHE_LOAD 2'd1
`endif
`ifndef D_CACHE_STORE
`define D_CACHE_STORE 2'd2
`endif
`ifndef D_CACHE_RESTING
`define D_CACHE_RESTING 2'd0
`endif
`ifndef L_S_FINISHED
`define L_S_FINISHED 2'd1
`endif
`ifndef D_CACHE_STALL
`define D_CACHE_STALL 2'd2
`endif

// state   | meaning
// S_IDLE  | req_ready high, waiting for a request
// S_ISSUE | waiting for the cache to rest, then launch element idx
// S_WAIT  | element idx in flight; first cycle is the cache acceptance slot
// S_DONE  | pulse done_valid, reopen req_ready
module vector_mem_sequencer #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_is_store,
  input  logic [ADDR_WIDTH-1:0]         req_base_addr,
  input  logic [LEN-1:0]                req_stride,
  input  logic [2:0]                    req_vsew,
  input  logic [ENTRY_INDEX_SIZE:0]     req_vl,
  input  logic [VECTOR_SIZE*LEN-1:0]    req_store_data,
`ifdef VECTOR_MASK_EN
  input  logic [VECTOR_SIZE-1:0]        req_mask,
`endif
  output logic                          done_valid,
  output logic [VECTOR_SIZE*LEN-1:0]    done_data,
  output logic                          done_error,
  output logic [ADDR_WIDTH-1:0]         data_addr,
  output logic [2:0]                    data_type,
  output logic [LEN-1:0]                cache_written_data,
  output logic [1:0]                    cache_vis_signal,
  output logic [ENTRY_INDEX_SIZE:0]     length,
  input  logic [1:0]                    d_cache_vis_status,
  input  logic [LEN-1:0]                data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [ENTRY_INDEX_SIZE:0] VL_MAX = (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE);

  state_t                       state;
  logic                         is_store;
  logic [ADDR_WIDTH-1:0]        addr_cur;
  logic [ADDR_WIDTH-1:0]        stride;
  logic [ENTRY_INDEX_SIZE:0]    vl;
  logic [ENTRY_INDEX_SIZE:0]    idx;
  logic [VECTOR_SIZE*LEN-1:0]   store_data;
  logic                         wait_first;
`ifdef VECTOR_MASK_EN
  logic [VECTOR_SIZE-1:0]       mask;
`endif

  logic [ENTRY_INDEX_SIZE:0]    req_vl_clamped;
  logic                         req_vsew_ok;
  logic [VECTOR_SIZE-1:0]       req_active;
  logic                         req_any_active;
  logic [ENTRY_INDEX_SIZE-1:0]  slot;
  logic [ENTRY_INDEX_SIZE:0]    idx_next;
  logic                         last_elem;
  logic [LEN-1:0]               width_mask;
  logic [LEN-1:0]               load_elem;
  logic [LEN-1:0]               cur_store_elem;
  logic                         unused_stride_hi;

  // Only the low address bits of the stride matter: the address wraps anyway.
  assign unused_stride_hi = ^req_stride[LEN-1:ADDR_WIDTH];

  // Every cache access is a single element.
  assign length = (ENTRY_INDEX_SIZE+1)'(1);

  // Request qualification and per-element datapath helpers.
  always_comb begin
    req_vl_clamped = (req_vl > VL_MAX) ? VL_MAX : req_vl;
    req_vsew_ok    = (req_vsew == `ONE_BYTE) || (req_vsew == `TWO_BYTE) ||
                     (req_vsew == `FOUR_BYTE);
    req_active     = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      req_active[i] = ((ENTRY_INDEX_SIZE+1)'(i) < req_vl_clamped);
    end
`ifdef VECTOR_MASK_EN
    req_active     = req_active & req_mask;
`endif
    req_any_active = |req_active;

    slot      = idx[ENTRY_INDEX_SIZE-1:0];
    idx_next  = idx + (ENTRY_INDEX_SIZE+1)'(1);
    last_elem = (idx_next == vl);

    case (data_type)
      `ONE_BYTE: width_mask = LEN'(8'hFF);
      `TWO_BYTE: width_mask = LEN'(16'hFFFF);
      default:   width_mask = '1;
    endcase
    load_elem      = data & width_mask;
    cur_store_elem = store_data[slot*LEN +: LEN];
  end

  // Sequencer FSM with registered cache-side and pipeline-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      req_ready          <= 1'b1;
      done_valid         <= 1'b0;
      done_data          <= '0;
      done_error         <= 1'b0;
      cache_vis_signal   <= `D_CACHE_NOP;
      data_addr          <= '0;
      data_type          <= `ONE_BYTE;
      cache_written_data <= '0;
      is_store           <= 1'b0;
      addr_cur           <= '0;
      stride             <= '0;
      vl                 <= '0;
      idx                <= '0;
      store_data         <= '0;
      wait_first         <= 1'b0;
`ifdef VECTOR_MASK_EN
      mask               <= '0;
`endif
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            is_store   <= req_is_store;
            addr_cur   <= req_base_addr;
            stride     <= req_stride[ADDR_WIDTH-1:0];
            data_type  <= req_vsew;
            vl         <= req_vl_clamped;
            store_data <= req_store_data;
`ifdef VECTOR_MASK_EN
            mask       <= req_mask;
`endif
            idx        <= '0;
            done_data  <= '0;
            done_error <= !req_vsew_ok;
            req_ready  <= 1'b0;
            // Nothing to access (empty, fully masked or bad width): finish now.
            state      <= (req_vsew_ok && req_any_active) ? S_ISSUE : S_DONE;
          end
        end

        S_ISSUE: begin
`ifdef VECTOR_MASK_EN
          if (!mask[slot]) begin
            idx      <= idx_next;
            addr_cur <= addr_cur + stride;
            state    <= last_elem ? S_DONE : S_ISSUE;
          end else
`endif
          if (d_cache_vis_status == `D_CACHE_RESTING) begin
            cache_vis_signal   <= is_store ? `D_CACHE_STORE : `D_CACHE_LOAD;
            data_addr          <= addr_cur;
            cache_written_data <= cur_store_elem;
            wait_first         <= 1'b1;
            state              <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_first) begin
            // Cache is sampling the request this cycle; its status is stale.
            cache_vis_signal <= `D_CACHE_NOP;
            wait_first       <= 1'b0;
          end else if (d_cache_vis_status == `L_S_FINISHED) begin
            if (!is_store) begin
              done_data[slot*LEN +: LEN] <= load_elem;
            end
            idx      <= idx_next;
            addr_cur <= addr_cur + stride;
            state    <= last_elem ? S_DONE : S_ISSUE;
          end
        end

        S_DONE: begin
          done_valid <= 1'b1;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Testbench for vector_mem_sequencer: directed and random requests against a
// cache responder and an element-list reference model.

`ifndef ONE_BYTE
`define ONE_BYTE 3'd0
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'd1
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'd2
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'd3
`endif
`ifndef D_CACHE_NOP
`define D_CACHE_NOP 2'd0
`endif
`ifndef D_CACHE_LOAD
`define D_CACHE_LOAD 2'd1
`endif
`ifndef D_CACHE_STORE
`define D_CACHE_STORE 2'd2
`endif
`ifndef D_CACHE_RESTING
`define D_CACHE_RESTING 2'd0
`endif
`ifndef L_S_FINISHED
`define L_S_FINISHED 2'd1
`endif
`ifndef D_CACHE_STALL
`define D_CACHE_STALL 2'd2
`endif

module tb_vector_mem_sequencer;
  localparam int AW  = 17;
  localparam int LEN = 32;
  localparam int VS  = 8;
  localparam int EIS = 3;
  localparam int DW  = VS*LEN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_is_store = 1'b0;
  logic [AW-1:0]   req_base_addr = '0;
  logic [LEN-1:0]  req_stride = '0;
  logic [2:0]      req_vsew = '0;
  logic [EIS:0]    req_vl = '0;
  logic [DW-1:0]   req_store_data = '0;
`ifdef VECTOR_MASK_EN
  logic [VS-1:0]   req_mask = '1;
`endif
  logic            done_valid;
  logic [DW-1:0]   done_data;
  logic            done_error;
  logic [AW-1:0]   data_addr;
  logic [2:0]      data_type;
  logic [LEN-1:0]  cache_written_data;
  logic [1:0]      cache_vis_signal;
  logic [EIS:0]    length;
  logic [1:0]      d_cache_vis_status = `D_CACHE_RESTING;
  logic [LEN-1:0]  data = '0;

  typedef struct packed {
    logic [1:0]     sig;
    logic [AW-1:0]  addr;
    logic [2:0]     dtype;
    logic [LEN-1:0] wdata;
  } acc_t;

  acc_t    obs_q[$];
  acc_t    exp_q[$];
  acc_t    resp_rec;
  int      stall_len = 0;
  int      busy_pct = 0;
  int      viol = 0;
  int      rcnt = -1;
  logic [AW-1:0] cur_addr = '0;
  logic    cur_st = 1'b0;
  int      checks = 0;
  int      errors = 0;

  vector_mem_sequencer #(
    .ADDR_WIDTH(AW), .LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_is_store(req_is_store),
    .req_base_addr(req_base_addr),
    .req_stride(req_stride),
    .req_vsew(req_vsew),
    .req_vl(req_vl),
    .req_store_data(req_store_data),
`ifdef VECTOR_MASK_EN
    .req_mask(req_mask),
`endif
    .done_valid(done_valid),
    .done_data(done_data),
    .done_error(done_error),
    .data_addr(data_addr),
    .data_type(data_type),
    .cache_written_data(cache_written_data),
    .cache_vis_signal(cache_vis_signal),
    .length(length),
    .d_cache_vis_status(d_cache_vis_status),
    .data(data)
  );

  always #5 clk = ~clk;

  function automatic logic [LEN-1:0] wmask(input logic [2:0] v);
    case (v)
      `ONE_BYTE: return 32'h0000_00FF;
      `TWO_BYTE: return 32'h0000_FFFF;
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Contents of the backing memory as seen through the cache.
  function automatic logic [LEN-1:0] mem_val(input logic [AW-1:0] a);
    case (a)
      17'h00100: return 32'h11;
      17'h00104: return 32'h22;
      17'h00108: return 32'h33;
      17'h0010C: return 32'h44;
      default:   return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Cache responder: logs each request, stalls stall_len cycles, then finishes.
  always @(negedge clk) begin
    if (!rst_n) begin
      d_cache_vis_status = `D_CACHE_RESTING;
      rcnt = -1;
    end else if (cache_vis_signal !== `D_CACHE_NOP) begin
      if (d_cache_vis_status !== `D_CACHE_RESTING || rcnt >= 0) viol++;
      resp_rec.sig   = cache_vis_signal;
      resp_rec.addr  = data_addr;
      resp_rec.dtype = data_type;
      resp_rec.wdata = cache_written_data;
      obs_q.push_back(resp_rec);
      cur_addr = data_addr;
      cur_st   = (cache_vis_signal === `D_CACHE_STORE);
      rcnt     = stall_len;
      d_cache_vis_status = `D_CACHE_STALL;
    end else if (rcnt > 0) begin
      rcnt--;
      d_cache_vis_status = `D_CACHE_STALL;
    end else if (rcnt == 0) begin
      d_cache_vis_status = `L_S_FINISHED;
      data = cur_st ? LEN'($urandom) : mem_val(cur_addr);
      rcnt = -1;
    end else begin
      d_cache_vis_status = (int'($urandom_range(99)) < busy_pct) ? `D_CACHE_STALL
                                                                  : `D_CACHE_RESTING;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/req_ready"}, 256'(req_ready), 256'(1'b1));
    chk({tag, "/done_valid"}, 256'(done_valid), 256'(1'b0));
    chk({tag, "/done_data"}, 256'(done_data), 256'(0));
    chk({tag, "/done_error"}, 256'(done_error), 256'(1'b0));
    chk({tag, "/cache_sig"}, 256'(cache_vis_signal), 256'(`D_CACHE_NOP));
    chk({tag, "/data_addr"}, 256'(data_addr), 256'(0));
    chk({tag, "/data_type"}, 256'(data_type), 256'(`ONE_BYTE));
    chk({tag, "/wdata"}, 256'(cache_written_data), 256'(0));
    chk({tag, "/length"}, 256'(length), 256'(1));
  endtask

  // One request end to end; exp_lat < 0 skips the latency check.
  task automatic do_req(input string name, input logic st, input logic [AW-1:0] base,
                        input logic [LEN-1:0] stride, input logic [2:0] vsew,
                        input logic [EIS:0] vl, input logic [DW-1:0] sdata,
                        input logic [VS-1:0] mask, input int stall, input int busy,
                        input int exp_lat);
    logic [DW-1:0] exp_dd;
    logic [VS-1:0] eff_mask;
    logic [AW-1:0] a;
    logic          vsew_ok;
    acc_t          e;
    acc_t          o;
    int            vlc;
    int            cyc;
    int            n;
    bit            got;

    // Reference: list of element accesses and the packed result.
`ifdef VECTOR_MASK_EN
    eff_mask = mask;
`else
    eff_mask = '1;
`endif
    vsew_ok = (vsew == `ONE_BYTE) || (vsew == `TWO_BYTE) || (vsew == `FOUR_BYTE);
    vlc = (int'(vl) > VS) ? VS : int'(vl);
    exp_q.delete();
    exp_dd = '0;
    if (vsew_ok) begin
      for (int k = 0; k < vlc; k++) begin
        if (eff_mask[k]) begin
          a = AW'(int'(base) + k * $signed(stride));
          e.sig   = st ? `D_CACHE_STORE : `D_CACHE_LOAD;
          e.addr  = a;
          e.dtype = vsew;
          e.wdata = st ? (sdata[k*LEN +: LEN] & wmask(vsew)) : '0;
          exp_q.push_back(e);
          if (!st) exp_dd[k*LEN +: LEN] = mem_val(a) & wmask(vsew);
        end
      end
    end

    obs_q.delete();
    stall_len = stall;
    busy_pct  = busy;
    viol      = 0;
    @(negedge clk);
    chk({name, "/ready_before"}, 256'(req_ready), 256'(1'b1));
    req_valid      = 1'b1;
    req_is_store   = st;
    req_base_addr  = base;
    req_stride     = stride;
    req_vsew       = vsew;
    req_vl         = vl;
    req_store_data = sdata;
`ifdef VECTOR_MASK_EN
    req_mask       = mask;
`endif
    @(posedge clk);
    #1;
    // Keep req_valid high with different fields while busy: must be ignored.
    req_is_store   = ~st;
    req_base_addr  = AW'($urandom);
    req_stride     = LEN'($urandom);
    req_vsew       = 3'($urandom);
    req_vl         = 4'($urandom);
    req_store_data = ~sdata;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done_valid === 1'b1) got = 1'b1;
    end
    req_valid = 1'b0;

    chk({name, "/done_seen"}, 256'(got), 256'(1'b1));
    if (exp_lat >= 0) chk({name, "/latency"}, 256'(cyc), 256'(exp_lat));
    chk({name, "/done_data"}, 256'(done_data), 256'(exp_dd));
    chk({name, "/done_error"}, 256'(done_error), 256'(!vsew_ok));
    chk({name, "/n_access"}, 256'(obs_q.size()), 256'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs_q[i];
      o.wdata = st ? (o.wdata & wmask(o.dtype)) : '0;
      chk($sformatf("%s/access%0d", name, i), 256'(o), 256'(exp_q[i]));
    end
    chk({name, "/protocol"}, 256'(viol), 256'(0));
    @(negedge clk);
    chk({name, "/pulse_one"}, 256'(done_valid), 256'(1'b0));
    chk({name, "/ready_after"}, 256'(req_ready), 256'(1'b1));
    chk({name, "/data_held"}, 256'(done_data), 256'(exp_dd));
  endtask

  initial begin
    logic [DW-1:0] sd;
    logic [VS-1:0] m;
    logic [2:0]    vs;
    logic [EIS:0]  vl_r;
    logic [LEN-1:0] str;
    int            r;
    int            stl;
    int            bsy;
    int            lat;
    int            nact;
    bit            st_r;

    for (int k = 0; k < VS; k++) sd[k*LEN +: LEN] = $urandom;

    // Reset with a request pending.
    rst_n          = 1'b0;
    req_valid      = 1'b1;
    req_is_store   = 1'b0;
    req_base_addr  = 17'h00100;
    req_stride     = 32'd4;
    req_vsew       = `FOUR_BYTE;
    req_vl         = 4'd4;
    repeat (4) begin
      @(negedge clk);
      chk("reset/no_request", 256'(cache_vis_signal), 256'(`D_CACHE_NOP));
    end
    chk_reset("reset");
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("reset/no_access", 256'(obs_q.size()), 256'(0));

    do_req("load4", 1'b0, 17'h00100, 32'd4, `FOUR_BYTE, 4'd4, sd, '1, 0, 0, 4*3 + 2);
    do_req("store_neg", 1'b1, 17'h00010, -32'sd1, `ONE_BYTE, 4'd3, sd, '1, 0, 0, 3*3 + 2);
    do_req("vl_zero", 1'b0, 17'h00200, 32'd4, `FOUR_BYTE, 4'd0, sd, '1, 0, 0, 2);
    do_req("bad_vsew", 1'b0, 17'h00200, 32'd8, `EIGHT_BYTE, 4'd4, sd, '1, 0, 0, 2);
    do_req("stall20", 1'b0, 17'h00400, 32'd2, `TWO_BYTE, 4'd3, sd, '1, 20, 0, 3*23 + 2);
    do_req("clamp", 1'b0, 17'h1FFF0, 32'd4, `FOUR_BYTE, 4'd15, sd, '1, 0, 0, 8*3 + 2);
    do_req("busy_store", 1'b1, 17'h00020, 32'd3, `TWO_BYTE, 4'd5, sd, '1, 1, 40, -1);
`ifdef VECTOR_MASK_EN
    do_req("mask_a5", 1'b0, 17'h00100, 32'd4, `FOUR_BYTE, 4'd8, sd, 8'b1010_0101, 0, 0, -1);
    do_req("mask_zero", 1'b0, 17'h00100, 32'd4, `FOUR_BYTE, 4'd5, sd, 8'h00, 0, 0, 2);
`endif

    // Reset in the middle of a load: abandoned, no done pulse.
    stall_len = 5;
    busy_pct  = 0;
    @(negedge clk);
    req_valid      = 1'b1;
    req_is_store   = 1'b0;
    req_base_addr  = 17'h00300;
    req_stride     = 32'd4;
    req_vsew       = `FOUR_BYTE;
    req_vl         = 4'd8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset/no_done", 256'(done_valid), 256'(1'b0));
    end
    chk_reset("midreset");
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midreset/no_late_done", 256'(done_valid), 256'(1'b0));
    end

    // Random requests.
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < VS; k++) sd[k*LEN +: LEN] = $urandom;
      st_r = 1'($urandom_range(1));
      r    = int'($urandom_range(9));
      vs   = (r < 9) ? 3'(r % 3) : 3'($urandom_range(7, 3));
      vl_r = 4'($urandom_range(15));
      str  = ($urandom_range(1) == 1) ? LEN'(int'($urandom_range(32)) - 16) : LEN'($urandom);
`ifdef VECTOR_MASK_EN
      m    = ($urandom_range(2) == 0) ? '1 : VS'($urandom);
`else
      m    = '1;
`endif
      stl  = int'($urandom_range(3));
      bsy  = ($urandom_range(1) == 1) ? 0 : 30;
      nact = (vs <= 3'd2) ? ((int'(vl_r) > VS) ? VS : int'(vl_r)) : 0;
      lat  = (bsy == 0 && m == '1) ? nact * (3 + stl) + 2 : -1;
      do_req($sformatf("rand%0d", it), st_r, AW'($urandom), str, vs, vl_r, sd, m, stl, bsy, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
